// File: rtl/vram_dump_streamer_pkg.sv
// Shared definitions for the VRAM dump streamer: FSM encodings and frame-header field widths.
package vram_dump_streamer_pkg;

    localparam int HDR_HI_W = 3;
    localparam int HDR_LO_W = 8;
    localparam int MAX_RD_LATENCY = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_RD     = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SEND   = 3'd5,
        ST_CSUM   = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/vram_rd_pipe.sv
// Valid shift register that marks the cycle in which VRAM read data is usable.
module vram_rd_pipe
    import vram_dump_streamer_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic issue,
    output logic data_valid
);

    localparam int DEPTH = (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY :
                           (RD_LATENCY < 1) ? 1 : RD_LATENCY;

    logic [DEPTH-1:0] vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            vld_q <= (vld_q << 1) | DEPTH'(issue);
        end
    end

    assign data_valid = vld_q[DEPTH-1];

endmodule

// File: rtl/vram_dump_streamer.sv
// Walks the VRAM read port and emits a framed byte stream: size_hi, size_lo, data..., checksum.
//
// state   | meaning
// IDLE    | waiting for start; busy low
// HDR_HI  | presenting upper length byte
// HDR_LO  | presenting lower length byte
// RD      | driving the VRAM read address
// WAIT    | waiting out the read latency, capturing the byte
// SEND    | presenting the data byte
// CSUM    | presenting the running checksum
// DONE    | one-cycle done pulse
module vram_dump_streamer
    import vram_dump_streamer_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] vram_size,
    output logic [ADDR_W-1:0] vram_read_address,
    input  logic [DATA_W-1:0] vram_output,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] byte_q;
    logic              rd_issue;
    logic              rd_data_valid;
    logic [DATA_W-1:0] hdr_hi;
    logic [DATA_W-1:0] hdr_lo;

    assign hdr_hi = DATA_W'(len_q >> HDR_LO_W);
    assign hdr_lo = DATA_W'(len_q);

    vram_rd_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk        (clk),
        .reset      (reset),
        .flush      (abort),
        .issue      (rd_issue),
        .data_valid (rd_data_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            len_q             <= '0;
            addr_q            <= '0;
            sum_q             <= '0;
            byte_q            <= '0;
            vram_read_address <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            if (state_q == ST_WAIT && rd_data_valid) begin
                byte_q <= vram_output;
            end
            if (state_d == ST_RD) begin
                vram_read_address <= addr_d;
            end
        end
    end

    // tx_valid is gated by abort so a byte caught mid-handshake never transfers.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        addr_d   = addr_q;
        sum_d    = sum_q;
        rd_issue = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    len_d   = vram_size;
                    addr_d  = '0;
                    sum_d   = '0;
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                tx_valid = !abort;
                tx_data  = hdr_hi;
                if (tx_ready) begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                tx_valid = !abort;
                tx_data  = hdr_lo;
                if (tx_ready) begin
                    state_d = (len_q != '0) ? ST_RD : ST_CSUM;
                end
            end
            ST_RD: begin
                rd_issue = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (rd_data_valid) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = !abort;
                tx_data  = byte_q;
                if (tx_ready) begin
                    sum_d   = sum_q + byte_q;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = (addr_q + ADDR_W'(1) == len_q) ? ST_CSUM : ST_RD;
                end
            end
            ST_CSUM: begin
                tx_valid = !abort;
                tx_data  = sum_q;
                if (tx_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_vram_dump_streamer.sv
// Scoreboard bench for vram_dump_streamer: driver queues expected bytes, monitor pops on each transfer.
module tb_vram_dump_streamer;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] vram_size;
    logic [ADDR_W-1:0] vram_read_address;
    logic [DATA_W-1:0] vram_output;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    vram_dump_streamer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .vram_size         (vram_size),
        .vram_read_address (vram_read_address),
        .vram_output       (vram_output),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    // VRAM model with a RD_LAT-deep read pipeline
    logic [7:0] mem [0:2047];
    logic [7:0] rdq [RD_LAT];
    always @(posedge clk) begin
        rdq[0] <= mem[vram_read_address];
        for (int i = 1; i < RD_LAT; i++) rdq[i] <= rdq[i-1];
    end
    assign vram_output = rdq[RD_LAT-1];

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int busy_cycles = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) begin
                check("hold_valid", int'(tx_valid), 1);
                check("hold_data", int'(tx_data), int'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stray_byte: got %0h with no byte expected", tx_data);
                end else begin
                    check("stream_byte", int'(tx_data), int'(exp_q.pop_front()));
                end
            end
            if (done) done_cnt++;
            if (busy) busy_cycles++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_model_frame(input int n);
        int s = 0;
        exp_q.push_back(8'(n >> 8));
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[i]);
            s += int'(mem[i]);
        end
        exp_q.push_back(8'(s));
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen after %0d cycles", name, k);
        end
    endtask

    task automatic wait_byte(input string name, input logic [7:0] val, input int budget);
        int k = 0;
        while (!(tx_valid && tx_data == val) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(tx_valid && tx_data == val)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: byte %0h not presented after %0d cycles", name, val, k);
        end
    endtask

    // expected bytes are queued by the caller before this runs
    task automatic run_frame(input string name, input int n, input int exp_busy);
        int d0 = done_cnt;
        int b0 = busy_cycles;
        vram_size = ADDR_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(name, 10000);
        @(posedge clk); #1;
        check({name, "_busy_low"}, int'(busy), 0);
        check({name, "_done_once"}, done_cnt - d0, 1);
        check({name, "_busy_cycles"}, busy_cycles - b0, exp_busy);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tx_ready = 1'b1;
        vram_size = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[0] = 8'hAA;
        mem[1] = 8'h55;
        mem[2] = 8'h01;
        #2;
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_addr", int'(vram_read_address), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // size 3: AA+55+01 = 0x100 wraps to 00
        exp_q = '{8'h00, 8'h03, 8'hAA, 8'h55, 8'h01, 8'h00};
        run_frame("size3", 3, 13);

        // empty region: header then checksum only
        exp_q = '{8'h00, 8'h00, 8'h00};
        run_frame("size0", 0, 4);

        // back-pressure for 5 cycles on data byte 55
        exp_q = '{8'h00, 8'h03, 8'hAA, 8'h55, 8'h01, 8'h00};
        fork
            run_frame("stall", 3, 18);
            begin
                wait_byte("stall", 8'h55, 100);
                tx_ready = 1'b0;
                repeat (5) begin @(posedge clk); #1; end
                tx_ready = 1'b1;
            end
        join

        // abort while the 2nd data byte is offered
        exp_q = '{8'h00, 8'h03, 8'hAA};
        d0 = done_cnt;
        vram_size = 11'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_byte("abort", 8'h55, 100);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_tx_valid", int'(tx_valid), 0);
        check("abort_busy", int'(busy), 0);
        repeat (4) begin @(posedge clk); #1; end
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        check("abort_still_idle", int'(busy), 0);
        exp_q = '{8'h00, 8'h03, 8'hAA, 8'h55, 8'h01, 8'h00};
        run_frame("after_abort", 3, 13);

        // start and vram_size changes while busy are ignored
        exp_q = '{8'h00, 8'h03, 8'hAA, 8'h55, 8'h01, 8'h00};
        fork
            run_frame("start_busy", 3, 13);
            begin
                repeat (6) begin @(posedge clk); #1; end
                vram_size = 11'd5;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        check("start_abort_valid", int'(tx_valid), 0);
        @(posedge clk); #1;
        check("start_abort_busy2", int'(busy), 0);

        // asynchronous reset while a data byte is offered
        exp_q = '{8'h00, 8'h03, 8'hAA};
        vram_size = 11'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_byte("reset_mid", 8'h55, 100);
        reset = 1'b0;
        #1;
        check("arst_tx_valid", int'(tx_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_tx_data", int'(tx_data), 0);
        check("arst_addr", int'(vram_read_address), 0);
        check("arst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q = '{8'h00, 8'h03, 8'hAA, 8'h55, 8'h01, 8'h00};
        run_frame("after_reset", 3, 13);

        // full-size region with VRAM[i] = i[7:0]
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        push_model_frame(2047);
        check("max_hdr_hi", int'(exp_q[0]), 8'h07);
        check("max_hdr_lo", int'(exp_q[1]), 8'hFF);
        run_frame("size2047", 2047, 2047 * 3 + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
